// File: rtl/micro_sequencer_pkg.sv
// Shared opcode encoding and default sizes for the microprogram sequencer.
package micro_sequencer_pkg;

    localparam int AW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        CONT = 3'd0,
        JZ   = 3'd1,
        CJP  = 3'd2,
        CJS  = 3'd3,
        CRTN = 3'd4,
        LDCT = 3'd5,
        RPCT = 3'd6,
        PUSH = 3'd7
    } opcode_e;

endpackage

// File: rtl/micro_stack.sv
// Subroutine return-address LIFO. Pushing when full and popping when empty are
// silently ignored; the sequencer decides whether that counts as an error.
module micro_stack
    import micro_sequencer_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem_q [DEPTH];
    logic [CW-1:0] count_q;

    // Entries are never reset: only the fill count decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count_q <= '0;
        end else if (push && !full) begin
            mem_q[IW'(count_q)] <= din;
            count_q             <= count_q + CW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign top   = empty ? '0 : mem_q[IW'(count_q - CW'(1))];

endmodule

// File: rtl/micro_sequencer.sv
// Am2910-style microprogram sequencer: next-address mux, loop counter and a
// subroutine stack, with a sticky error flag for stack over/underflow.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          hold,
    input  logic [2:0]    inst,
    input  logic          cc,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] uaddr,
    output logic          stk_empty,
    output logic          stk_full,
    output logic          cnt_zero,
    output logic          stk_err
);

    logic [AW-1:0] uaddr_q, uaddr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          stkErr_q, stkErr_d;
    logic [AW-1:0] inc;
    logic [AW-1:0] stkTop;
    logic          stkPush, stkPop, stkClear, pushReq;

    micro_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (stkPush),
        .pop     (stkPop),
        .clear   (stkClear),
        .din     (inc),
        .top     (stkTop),
        .empty   (stk_empty),
        .full    (stk_full)
    );

    // A refused push still advances uaddr exactly as a successful one would.
    always_comb begin
        inc      = uaddr_q + AW'(1);
        uaddr_d  = uaddr_q;
        cnt_d    = cnt_q;
        stkErr_d = stkErr_q;
        stkPush  = 1'b0;
        stkPop   = 1'b0;
        stkClear = 1'b0;
        pushReq  = 1'b0;
        if (!hold) begin
            uaddr_d = inc;
            case (opcode_e'(inst))
                CONT: ;
                JZ: begin
                    uaddr_d  = '0;
                    stkClear = 1'b1;
                end
                CJP: if (cc) uaddr_d = d;
                CJS: begin
                    if (cc) begin
                        pushReq = 1'b1;
                        uaddr_d = d;
                    end
                end
                CRTN: begin
                    if (cc) begin
                        if (stk_empty) begin
                            stkErr_d = 1'b1;
                        end else begin
                            uaddr_d = stkTop;
                            stkPop  = 1'b1;
                        end
                    end
                end
                LDCT: cnt_d = d;
                RPCT: begin
                    if (cnt_q != '0) begin
                        cnt_d   = cnt_q - AW'(1);
                        uaddr_d = d;
                    end
                end
                PUSH: begin
                    pushReq = 1'b1;
                    if (cc) cnt_d = d;
                end
            endcase
            if (pushReq) begin
                if (stk_full) stkErr_d = 1'b1;
                else          stkPush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uaddr_q  <= '0;
            cnt_q    <= '0;
            stkErr_q <= 1'b0;
        end else begin
            uaddr_q  <= uaddr_d;
            cnt_q    <= cnt_d;
            stkErr_q <= stkErr_d;
        end
    end

    assign uaddr    = uaddr_q;
    assign cnt_zero = (cnt_q == '0);
    assign stk_err  = stkErr_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a behavioural model queues the expected
// state for every step, which is popped and compared one cycle later.
module tb_micro_sequencer;
    import micro_sequencer_pkg::*;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] uaddr;
        logic          empty;
        logic          full;
        logic          cz;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          hold = 1'b0;
    logic [2:0]    inst = 3'd0;
    logic          cc = 1'b0;
    logic [AW-1:0] d = '0;
    logic [AW-1:0] uaddr;
    logic          stk_empty, stk_full, cnt_zero, stk_err;

    int checks = 0;
    int errors = 0;

    exp_t          expQ[$];
    logic [AW-1:0] mStack[$];
    logic [AW-1:0] mUaddr = '0;
    logic [AW-1:0] mCnt = '0;
    logic          mErr = 1'b0;

    micro_sequencer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (hold),
        .inst      (inst),
        .cc        (cc),
        .d         (d),
        .uaddr     (uaddr),
        .stk_empty (stk_empty),
        .stk_full  (stk_full),
        .cnt_zero  (cnt_zero),
        .stk_err   (stk_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelPush(input logic [AW-1:0] val);
        if (mStack.size() >= DEPTH) mErr = 1'b1;
        else                        mStack.push_back(val);
    endtask

    // Drive one instruction, advance the model, queue its result, then compare after the edge.
    task automatic applyStimulus(input string tag, input logic rstN, input logic hld,
                                 input logic [2:0] op, input logic c, input logic [AW-1:0] dv);
        logic [AW-1:0] mInc;
        exp_t e, got;
        reset_n = rstN; hold = hld; inst = op; cc = c; d = dv;
        mInc = mUaddr + 8'd1;
        if (!rstN) begin
            mUaddr = '0; mCnt = '0; mErr = 1'b0; mStack.delete();
        end else if (!hld) begin
            case (op)
                3'd0: mUaddr = mInc;
                3'd1: begin mUaddr = '0; mStack.delete(); end
                3'd2: mUaddr = c ? dv : mInc;
                3'd3: if (c) begin modelPush(mInc); mUaddr = dv; end else mUaddr = mInc;
                3'd4: begin
                    if (c && mStack.size() > 0) mUaddr = mStack.pop_back();
                    else begin
                        if (c) mErr = 1'b1;
                        mUaddr = mInc;
                    end
                end
                3'd5: begin mCnt = dv; mUaddr = mInc; end
                3'd6: if (mCnt != 0) begin mCnt = mCnt - 8'd1; mUaddr = dv; end else mUaddr = mInc;
                default: begin modelPush(mInc); if (c) mCnt = dv; mUaddr = mInc; end
            endcase
        end
        e.uaddr = mUaddr;
        e.empty = (mStack.size() == 0);
        e.full  = (mStack.size() == DEPTH);
        e.cz    = (mCnt == 0);
        e.err   = mErr;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        got = expQ.pop_front();
        checkOutput({tag, ".uaddr"}, uaddr, got.uaddr);
        checkOutput({tag, ".empty"}, {7'd0, stk_empty}, {7'd0, got.empty});
        checkOutput({tag, ".full"},  {7'd0, stk_full},  {7'd0, got.full});
        checkOutput({tag, ".czero"}, {7'd0, cnt_zero},  {7'd0, got.cz});
        checkOutput({tag, ".err"},   {7'd0, stk_err},   {7'd0, got.err});
    endtask

    initial begin
        #2;
        applyStimulus("rst", 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        checkOutput("rst_uaddr", uaddr, 8'h00);
        checkOutput("rst_empty", {7'd0, stk_empty}, 8'd1);

        // Sequential counting and wrap at all-ones.
        for (int i = 0; i < 3; i++) applyStimulus("cont", 1'b1, 1'b0, CONT, 1'b0, 8'h00);
        checkOutput("cont3", uaddr, 8'h03);
        applyStimulus("cjp_ff", 1'b1, 1'b0, CJP, 1'b1, 8'hFF);
        applyStimulus("wrap", 1'b1, 1'b0, CONT, 1'b0, 8'h00);
        checkOutput("wrap_uaddr", uaddr, 8'h00);
        applyStimulus("cjp_nc", 1'b1, 1'b0, CJP, 1'b0, 8'h77);

        // Subroutine call and return.
        applyStimulus("to10", 1'b1, 1'b0, CJP, 1'b1, 8'h10);
        applyStimulus("cjs", 1'b1, 1'b0, CJS, 1'b1, 8'h40);
        checkOutput("cjs_uaddr", uaddr, 8'h40);
        applyStimulus("crtn", 1'b1, 1'b0, CRTN, 1'b1, 8'h00);
        checkOutput("crtn_uaddr", uaddr, 8'h11);
        applyStimulus("cjs_nc", 1'b1, 1'b0, CJS, 1'b0, 8'h40);
        applyStimulus("crtn_nc", 1'b1, 1'b0, CRTN, 1'b0, 8'h00);

        // Counted loop: body at 20 is CONT, RPCT at 21 jumps back.
        applyStimulus("to20", 1'b1, 1'b0, CJP, 1'b1, 8'h20);
        applyStimulus("ldct", 1'b1, 1'b0, LDCT, 1'b0, 8'h03);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("rpct", 1'b1, 1'b0, RPCT, 1'b0, 8'h20);
            checkOutput("rpct_back", uaddr, 8'h20);
            applyStimulus("body", 1'b1, 1'b0, CONT, 1'b0, 8'h00);
        end
        applyStimulus("rpct_end", 1'b1, 1'b0, RPCT, 1'b0, 8'h20);
        checkOutput("loop_exit", uaddr, 8'h22);
        checkOutput("loop_cz", {7'd0, cnt_zero}, 8'd1);

        // Overflow: fifth push refused, top still the fourth return address.
        applyStimulus("rst2", 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) applyStimulus("push", 1'b1, 1'b0, PUSH, 1'b0, 8'h00);
        checkOutput("ovf_full", {7'd0, stk_full}, 8'd1);
        checkOutput("ovf_err", {7'd0, stk_err}, 8'd1);
        applyStimulus("pop_top", 1'b1, 1'b0, CRTN, 1'b1, 8'h00);
        checkOutput("top_kept", uaddr, 8'h04);
        applyStimulus("jz", 1'b1, 1'b0, JZ, 1'b0, 8'h00);
        checkOutput("jz_err_kept", {7'd0, stk_err}, 8'd1);

        // Underflow, then hold freezes everything.
        applyStimulus("rst3", 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        applyStimulus("unf", 1'b1, 1'b0, CRTN, 1'b1, 8'h00);
        checkOutput("unf_uaddr", uaddr, 8'h01);
        applyStimulus("hold", 1'b1, 1'b1, CJP, 1'b1, 8'h55);
        checkOutput("hold_uaddr", uaddr, 8'h01);
        applyStimulus("hold_push", 1'b1, 1'b1, PUSH, 1'b1, 8'h09);

        // Reset mid-subroutine/mid-loop beats hold and discards state.
        applyStimulus("rst4", 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        applyStimulus("push_ld", 1'b1, 1'b0, PUSH, 1'b1, 8'h05);
        applyStimulus("push2", 1'b1, 1'b0, PUSH, 1'b0, 8'h00);
        applyStimulus("rst_hold", 1'b0, 1'b1, CJP, 1'b1, 8'h55);
        checkOutput("rst_cz", {7'd0, cnt_zero}, 8'd1);
        checkOutput("rst_empty2", {7'd0, stk_empty}, 8'd1);
        applyStimulus("resume", 1'b1, 1'b0, CONT, 1'b0, 8'h00);
        checkOutput("resume_uaddr", uaddr, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
